// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory arbiter
package mem_ctrl_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requester identifier: 0 or 1
  typedef logic id_t;

  // Default number of WAIT cycles before a transaction is abandoned
  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin winner selection
module rr_pick2
  import mem_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  id_t  last,
  output id_t  win,
  output logic any
);

  // A tie goes to the requester that was not served last; otherwise the lone requester wins
  assign win = (req0 && req1) ? ~last : req1;
  assign any = req0 | req1;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory unit between two requesters
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [DATA_W-1:0] mem_a,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_done,
  output logic              busy
);

  // Last WAIT count value before the transaction is abandoned
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  id_t        id;
  id_t        last;
  logic [7:0] cnt;
  id_t        win;
  logic       any;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // Sequencer: every output is registered and computed from the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      id         <= 1'b0;
      last       <= 1'b1;
      cnt        <= 8'd0;
      mem_a      <= '0;
      mem_enable <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Pulsed outputs default low; rdata/err are only meaningful alongside ack
      mem_enable <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            id         <= win;
            mem_a      <= win ? a1 : a0;
            mem_enable <= 1'b1;
            gnt0       <= ~win;
            gnt1       <= win;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion on the final count still wins over the timeout
          if (mem_done) begin
            rdata <= mem_q;
            err   <= 1'b0;
            ack0  <= ~id;
            ack1  <= id;
            state <= RESP;
          end else if (cnt == TMO_LAST) begin
            rdata <= '0;
            err   <= 1'b1;
            ack0  <= ~id;
            ack1  <= id;
            state <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          last  <= id;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized transaction-level bench for mem_arbiter
module tb_mem_arbiter;

  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [DW-1:0] a0, a1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata;
  logic          err;
  logic [DW-1:0] mem_a;
  logic          mem_enable;
  logic [DW-1:0] mem_q;
  logic          mem_done;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int last_srv;
  int n_en;

  always #5 clock = ~clock;

  mem_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .a1         (a1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata      (rdata),
    .err        (err),
    .mem_a      (mem_a),
    .mem_enable (mem_enable),
    .mem_q      (mem_q),
    .mem_done   (mem_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
    if (mem_enable) n_en++;
  endtask

  // One transaction starting from an IDLE cycle; expectations come from the arbitration rules
  task automatic run_txn(input bit r0, input bit r1, input int d, input bit gap, input bit drop,
                         input bit fixed, input logic [DW-1:0] fa0, input logic [DW-1:0] fq);
    logic [DW-1:0] av0, av1, aw, q;
    int w;
    if (gap) begin
      req0 = 1'b0; req1 = 1'b0; mem_done = 1'b1; mem_q = DW'($urandom);
      step;
      chk("idle_busy", busy, 0);
      chk("idle_ack", {ack1, ack0}, 0);
      chk("idle_en", mem_enable, 0);
      mem_done = 1'b0;
    end
    av0 = fixed ? fa0 : DW'($urandom);
    av1 = DW'($urandom);
    a0 = av0; a1 = av1; req0 = r0; req1 = r1;
    w  = (r0 && r1) ? (last_srv == 1 ? 0 : 1) : (r1 ? 1 : 0);
    aw = (w == 1) ? av1 : av0;
    n_en = 0;
    mem_done = 1'($urandom_range(0, 1)); mem_q = DW'($urandom);
    step;
    chk("issue_en", mem_enable, 1);
    chk("issue_a", mem_a, aw);
    chk("issue_gnt", {gnt1, gnt0}, (w == 1) ? 2 : 1);
    chk("issue_busy", busy, 1);
    if (drop) begin req0 = 1'b0; req1 = 1'b0; end
    mem_done = 1'($urandom_range(0, 1)); mem_q = DW'($urandom);
    a0 = DW'($urandom); a1 = DW'($urandom);
    step;
    chk("wait_en", mem_enable, 0);
    chk("wait_a", mem_a, aw);
    chk("wait_gnt", {gnt1, gnt0}, (w == 1) ? 2 : 1);
    for (int k = 0; k < TMO; k++) begin
      mem_done = (k == d);
      q = (fixed && k == d) ? fq : DW'($urandom);
      mem_q = q;
      step;
      chk("resp_gnt", {gnt1, gnt0}, (w == 1) ? 2 : 1);
      if (k == d || k == TMO - 1) begin
        chk("ack", {ack1, ack0}, (w == 1) ? 2 : 1);
        chk("rdata", rdata, (k == d) ? q : 0);
        chk("err", err, (k == d) ? 0 : 1);
        break;
      end else begin
        chk("early_ack", {ack1, ack0}, 0);
        chk("wait_rdata", rdata, 0);
        chk("wait_busy", busy, 1);
      end
    end
    mem_done = 1'($urandom_range(0, 1)); mem_q = DW'($urandom);
    step;
    chk("end_busy", busy, 0);
    chk("end_gnt", {gnt1, gnt0}, 0);
    chk("end_ack", {ack1, ack0}, 0);
    chk("end_rdata", rdata, 0);
    chk("end_err", err, 0);
    chk("en_count", n_en, 1);
    mem_done = 1'b0;
    last_srv = w;
  endtask

  // Reset dropped in the middle of WAIT: outputs clear at once and no ack ever follows
  task automatic run_abort;
    req0 = 1'b1; req1 = 1'($urandom_range(0, 1)); mem_done = 1'b0;
    step; step; step; step;
    reset = 1'b1;
    #1;
    chk("abort_en", mem_enable, 0);
    chk("abort_gnt", {gnt1, gnt0}, 0);
    chk("abort_busy", busy, 0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    last_srv = 1;
    step;
    chk("abort_noack", {ack1, ack0}, 0);
    chk("abort_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0; mem_q = '0; mem_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_en", mem_enable, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    last_srv = 1;

    repeat (4) run_txn(1, 1, $urandom_range(0, 3), 0, 0, 0, '0, '0);
    run_txn(1, 0, 0, 1, 0, 1, 16'h1234, 16'hBEEF);
    run_txn(1, 0, 99, 0, 0, 0, '0, '0);
    run_txn(0, 1, 2, 0, 0, 0, '0, '0);
    run_txn(1, 1, TMO - 1, 0, 0, 0, '0, '0);
    run_txn(0, 1, 3, 0, 1, 0, '0, '0);
    run_txn(1, 0, 1, 1, 0, 0, '0, '0);
    run_abort;
    run_txn(1, 1, 1, 0, 0, 0, '0, '0);

    repeat (40) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(r0, r1, $urandom_range(0, TMO + 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: width of the address and data paths. Legal values are 4 and 16, matching the 4-bit and 16-bit memory units.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: the maximum number of WAIT cycles before a transaction is aborted. Legal range is 1..255.
REQ-003 The block SHALL have a single clock, port clock, input, 1 bit; all flops SHALL be rising-edge triggered on it.
REQ-004 Port reset SHALL be an input, 1 bit, asynchronous and active-high.
REQ-005 Ports req0 and req1 SHALL be inputs, 1 bit each: access request from requester 0 and requester 1.
REQ-006 Ports a0 and a1 SHALL be inputs, DATA_W bits each: the operand/address of each requester.
REQ-007 Ports gnt0 and gnt1 SHALL be outputs, 1 bit each: requester owns the memory unit.
REQ-008 Ports ack0 and ack1 SHALL be outputs, 1 bit each: one-cycle completion pulse.
REQ-009 Port rdata SHALL be an output, DATA_W bits: result, valid only while ack0 or ack1 is high.
REQ-010 Port err SHALL be an output, 1 bit: the completing transaction timed out; qualified by ack.
REQ-011 Port mem_a SHALL be an output, DATA_W bits, driving the memory unit operand.
REQ-012 Port mem_enable SHALL be an output, 1 bit, driving the memory unit enable.
REQ-013 Port mem_q SHALL be an input, DATA_W bits: the memory unit result.
REQ-014 Port mem_done SHALL be an input, 1 bit: the memory unit completion flag.
REQ-015 Port busy SHALL be an output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req is sampled high, the block SHALL latch the winner id and its operand and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with only one req high, that requester wins; with both high, the requester not served last wins.
REQ-019 The last-served pointer SHALL be updated only in RESP.
REQ-020 ISSUE: mem_enable SHALL be 1 for exactly this one cycle, mem_a SHALL carry the latched operand, and the next state SHALL be WAIT.
REQ-021 WAIT: mem_enable SHALL be 0, mem_a SHALL hold the latched operand, and a wait counter SHALL increment each cycle from 0.
REQ-022 WAIT with mem_done=1: the block SHALL capture mem_q, clear the error flag and go to RESP.
REQ-023 WAIT with mem_done=0 and the counter equal to TIMEOUT-1: the block SHALL capture 0, set the error flag and go to RESP.
REQ-024 If mem_done and the timeout condition coincide, mem_done SHALL take priority and err SHALL be 0.
REQ-025 RESP: the block SHALL pulse the ack of the latched id for one cycle, drive rdata with the captured value and err with the flag, then go to IDLE.
REQ-026 gnt of the latched id SHALL be high through ISSUE, WAIT and RESP; the gnt outputs SHALL be one-hot or zero, never both high.
REQ-027 Latency: with req sampled at edge N, mem_enable SHALL be high in cycle N+1; with mem_done in the first WAIT cycle, ack SHALL be high in cycle N+3.
REQ-028 Deasserting req after it has been granted SHALL NOT abort the transaction; ack is still issued.
REQ-029 After RESP the block SHALL return to IDLE for at least one cycle; a req still high in that cycle SHALL be treated as a new request.
REQ-030 mem_done seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-031 rdata SHALL be 0 whenever no ack is high.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On reset assertion, state SHALL go to IDLE immediately and asynchronously, aborting any transaction in flight with no ack.
REQ-034 On reset, mem_enable, gnt0, gnt1, ack0, ack1, err and busy SHALL go to 0, and mem_a, rdata and the wait counter SHALL go to 0.
REQ-035 On reset, the last-served pointer SHALL be set to 1, so requester 0 wins the first tie.

Structure
REQ-036 Package mem_ctrl_pkg SHALL hold the state enum, the requester id type and the default TIMEOUT constant.
REQ-037 A single sub-module rr_pick2 SHALL hold the combinational round-robin winner logic (req0, req1, last → win, any); the FSM and counters SHALL stay in mem_arbiter.

Verification
REQ-038 Scenario: req0=1 alone with a0=0x1234, mem_done one cycle after mem_enable with mem_q=0xBEEF -> gnt0=1, one mem_enable pulse with mem_a=0x1234, ack0 at N+3, rdata=0xBEEF, err=0.
REQ-039 Scenario: req0 and req1 both held high from reset -> service order 0,1,0,1; gnt never both high; exactly one mem_enable per transaction.
REQ-040 Scenario: TIMEOUT=15 and mem_done never asserted -> ack after 15 WAIT cycles with err=1 and rdata=0; the next transaction completes normally with err=0.
REQ-041 Scenario: mem_done asserted exactly on the final WAIT cycle -> err=0 and rdata=mem_q.
REQ-042 Scenario: reset asserted mid-WAIT -> mem_enable, gnt and busy go to 0 asynchronously; no ack follows; after release, req1 and req0 together -> req0 wins.
REQ-043 Scenario: req1 dropped during WAIT, and mem_done pulsed while IDLE -> ack1 still issued; the stray mem_done produces no ack and no state change.
